// File: rtl/mux_gate_pipe.sv
// -----------------------------------------------------------------------------
// mux_gate_pipe
//
// Two-stage valid/ready pipeline that applies one of eight bitwise logic
// functions to two WIDTH-bit operands. Every result bit is a 2:1 mux steered
// by operand A: y[i] = a[i] ? f(1, b[i]) : f(0, b[i]).
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   CNT_W  width of the completed-transaction counter (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   in_a       operand A (per-bit mux select)
//   in_b       operand B (per-bit mux data)
//   in_op      function select (0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR,
//              6 PASS_A, 7 NOT_A)
//   out_valid  result beat valid
//   out_ready  consumer accepts result this cycle
//   out_y      result
//   out_zero   registered flag, 1 when out_y == 0
//   out_op     opcode that produced out_y
//   done_cnt   wrapping count of consumed results (out_valid & out_ready)
//   out_parity XOR-reduction of out_y, registered with it
//              (present only when MUX_GATE_PIPE_PARITY_EN is defined)
//
// Optional feature macro: MUX_GATE_PIPE_PARITY_EN
// -----------------------------------------------------------------------------
module mux_gate_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] done_cnt
`ifdef MUX_GATE_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic             s2_zero;
  op_e              s2_op;

  // ---------------------------------------------------------------------------
  // Handshake / advance control
  // ---------------------------------------------------------------------------
  logic s1_adv;
  logic s2_adv;
  logic accept;
  logic consume;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;
  assign consume  = s2_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Mux-form function evaluation on the S1 contents.
  // f0 is the value each bit takes when a[i] = 0, f1 when a[i] = 1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] f0;
  logic [WIDTH-1:0] f1;
  logic [WIDTH-1:0] s1_y;

  always_comb begin
    f0 = '0;
    f1 = '0;
    case (s1_op)
      OP_AND: begin
        f0 = '0;
        f1 = s1_b;
      end
      OP_OR: begin
        f0 = s1_b;
        f1 = '1;
      end
      OP_NAND: begin
        f0 = '1;
        f1 = ~s1_b;
      end
      OP_NOR: begin
        f0 = ~s1_b;
        f1 = '0;
      end
      OP_XOR: begin
        f0 = s1_b;
        f1 = ~s1_b;
      end
      OP_XNOR: begin
        f0 = ~s1_b;
        f1 = s1_b;
      end
      OP_PASS_A: begin
        f0 = '0;
        f1 = '1;
      end
      OP_NOT_A: begin
        f0 = '1;
        f1 = '0;
      end
      default: begin
        f0 = '0;
        f1 = '0;
      end
    endcase
  end

  always_comb begin
    s1_y = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1_y[i] = s1_a[i] ? f1[i] : f0[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: operand capture. When S1 advances without a new beat it empties.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= op_e'(in_op);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: result register. Holds every field while stalled so the output
  // stays stable under back-pressure. The zero flag is derived from the S1
  // result, not from the output port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_zero  <= 1'b1;
      s2_op    <= OP_AND;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_y     <= s1_y;
      s2_zero  <= ~|s1_y;
      s2_op    <= s1_op;
    end
  end

`ifdef MUX_GATE_PIPE_PARITY_EN
  logic s2_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_par <= 1'b0;
    end else if (s2_adv) begin
      s2_par <= ^s1_y;
    end
  end

  assign out_parity = s2_par;
`endif

  // ---------------------------------------------------------------------------
  // Completed-transaction counter, wraps silently.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (consume) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_zero  = s2_zero;
  assign out_op    = s2_op;

endmodule

// File: tb/tb_mux_gate_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_gate_pipe
//
// Scoreboard bench for mux_gate_pipe. Two instances: an 8-bit one with a
// 4-bit counter (function, back-pressure, wrap, reset) and a 1-bit one for
// exhaustive truth tables. Expected beats are pushed at accept and compared
// against observed beats in order.
// -----------------------------------------------------------------------------
module tb_mux_gate_pipe;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    logic       z;
    logic       p;
    int         cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (WIDTH=8, CNT_W=4)
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
  logic       out_zero;
  logic [2:0] out_op;
  logic [3:0] done_cnt;
  logic       par_main;

  // 1-bit instance
  logic        v1 = 1'b0;
  logic        rdy1;
  logic        a1 = 1'b0;
  logic        b1 = 1'b0;
  logic [2:0]  op1 = '0;
  logic        ov1;
  logic        ordy1 = 1'b0;
  logic        y1;
  logic        z1;
  logic [2:0]  oop1;
  logic [15:0] cnt1;
  logic        par1;

  mux_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_op(out_op),
    .done_cnt(done_cnt)
`ifdef MUX_GATE_PIPE_PARITY_EN
    , .out_parity(par_main)
`endif
  );

  mux_gate_pipe #(.WIDTH(1), .CNT_W(16)) dut_w1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(rdy1),
    .in_a(a1), .in_b(b1), .in_op(op1),
    .out_valid(ov1), .out_ready(ordy1),
    .out_y(y1), .out_zero(z1), .out_op(oop1),
    .done_cnt(cnt1)
`ifdef MUX_GATE_PIPE_PARITY_EN
    , .out_parity(par1)
`endif
  );

`ifndef MUX_GATE_PIPE_PARITY_EN
  assign par_main = 1'b0;
  assign par1     = 1'b0;
`endif

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  logic [3:0] cnt_model = '0;
  beat_t      exp_q[$];
  beat_t      rx_q[$];
  beat_t      exp1_q[$];
  beat_t      rx1_q[$];

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  // One clock: sample handshakes before the edge, record beats after it.
  task automatic tick(output bit acc);
    bit         cons, acc1, cons1;
    beat_t      e, r, e1, r1;
    logic [7:0] m;
    #1;
    acc   = in_valid && in_ready;
    cons  = out_valid && out_ready;
    acc1  = v1 && rdy1;
    cons1 = ov1 && ordy1;
    e.y = model(in_a, in_b, in_op); e.op = in_op; e.z = (e.y == 8'h00);
    e.p = ^e.y; e.cyc = cyc;
    r.y = out_y; r.op = out_op; r.z = out_zero; r.p = par_main; r.cyc = cyc;
    m = model({7'b0, a1}, {7'b0, b1}, op1);
    e1.y = {7'b0, m[0]}; e1.op = op1; e1.z = ~m[0]; e1.p = m[0]; e1.cyc = cyc;
    r1.y = {7'b0, y1}; r1.op = oop1; r1.z = z1; r1.p = par1; r1.cyc = cyc;
    @(posedge clk);
    cyc++;
    if (acc) exp_q.push_back(e);
    if (cons) begin
      rx_q.push_back(r);
      cnt_model++;
    end
    if (acc1) exp1_q.push_back(e1);
    if (cons1) rx1_q.push_back(r1);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete(); rx_q.delete(); exp1_q.delete(); rx1_q.delete();
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_y !== 8'h00) $display("FAIL reset_out_y: got %h want 00", out_y); else n_pass++;
    n_total++; if (out_zero !== 1'b1) $display("FAIL reset_out_zero: got %0b want 1", out_zero); else n_pass++;
    n_total++; if (out_op !== 3'd0) $display("FAIL reset_out_op: got %0d want 0", out_op); else n_pass++;
    n_total++; if (done_cnt !== 4'd0) $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); else n_pass++;
`ifdef MUX_GATE_PIPE_PARITY_EN
    n_total++; if (par_main !== 1'b0) $display("FAIL reset_parity: got %0b want 0", par_main); else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_stream();
    bit         acc;
    beat_t      e, r;
    int         prev;
    logic [7:0] tbl [8];
    tbl = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hF0, 8'h0F};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'hF0;
    in_b      = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      tick(acc);
      n_total++; if (!acc) $display("FAIL stream_accept: beat %0d got in_ready=0 want 1", i); else n_pass++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && rx_q.size() < 8; k++) tick(acc);
    n_total++; if (rx_q.size() != 8) $display("FAIL stream_count: got %0d want 8", rx_q.size()); else n_pass++;
    prev = 0;
    for (int i = 0; i < 8 && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (r.y !== tbl[i]) $display("FAIL stream_y[%0d]: got %h want %h", i, r.y, tbl[i]); else n_pass++;
      n_total++; if (r.y !== e.y || r.z !== e.z) $display("FAIL stream_model[%0d]: got %h/%0b want %h/%0b", i, r.y, r.z, e.y, e.z); else n_pass++;
      n_total++; if (r.op !== 3'(i)) $display("FAIL stream_op[%0d]: got %0d want %0d", i, r.op, i); else n_pass++;
      if (i == 0) begin
        n_total++; if (r.cyc - e.cyc != 2) $display("FAIL stream_latency: got %0d want 2", r.cyc - e.cyc); else n_pass++;
      end else begin
        n_total++; if (r.cyc != prev + 1) $display("FAIL stream_b2b[%0d]: got gap %0d want 1", i, r.cyc - prev); else n_pass++;
      end
      prev = r.cyc;
    end
    clear_queues();
  endtask

  task automatic test_truth_w1();
    bit    acc;
    beat_t e, r;
    logic [1:0] ab;
    ordy1 = 1'b1;
    v1    = 1'b1;
    for (int op = 0; op < 6; op++) begin
      for (int k = 0; k < 4; k++) begin
        ab  = 2'(k);
        op1 = 3'(op);
        a1  = ab[1];
        b1  = ab[0];
        tick(acc);
      end
    end
    v1 = 1'b0;
    for (int k = 0; k < 12 && rx1_q.size() < 24; k++) tick(acc);
    n_total++; if (rx1_q.size() != 24 || exp1_q.size() != 24) $display("FAIL w1_count: got %0d/%0d want 24", rx1_q.size(), exp1_q.size()); else n_pass++;
    for (int i = 0; i < 24 && rx1_q.size() > 0 && exp1_q.size() > 0; i++) begin
      r = rx1_q.pop_front();
      e = exp1_q.pop_front();
      n_total++;
      if (r.y !== e.y || r.op !== e.op || r.z !== e.z)
        $display("FAIL w1_truth[op%0d ab%0d]: got y=%0b op=%0d z=%0b want y=%0b op=%0d z=%0b",
                 i / 4, i % 4, r.y[0], r.op, r.z, e.y[0], e.op, e.z);
      else n_pass++;
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    bit         acc;
    int         idx;
    beat_t      e, r;
    logic [7:0] hold_y;
    logic [2:0] hold_op;
    logic [7:0] ba [4];
    logic [7:0] bb [4];
    logic [2:0] bo [4];
    ba = '{8'h3C, 8'h81, 8'hFF, 8'h55};
    bb = '{8'hA5, 8'h7E, 8'h0F, 8'h33};
    bo = '{3'd4, 3'd1, 3'd2, 3'd5};
    idx = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a = ba[idx]; in_b = bb[idx]; in_op = bo[idx];
      tick(acc);
      if (acc) idx++;
    end
    n_total++; if (idx != 2) $display("FAIL bp_accepts: got %0d want 2", idx); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_y !== model(ba[0], bb[0], bo[0]))
      $display("FAIL bp_head: got v=%0b y=%h want v=1 y=%h", out_valid, out_y, model(ba[0], bb[0], bo[0]));
    else n_pass++;
    hold_y  = out_y;
    hold_op = out_op;
    in_a = ba[idx]; in_b = bb[idx]; in_op = bo[idx];
    tick(acc);
    if (acc) idx++;
    n_total++; if (out_y !== hold_y || out_op !== hold_op || idx != 2)
      $display("FAIL bp_hold: got y=%h op=%0d accepts=%0d want y=%h op=%0d accepts=2", out_y, out_op, idx, hold_y, hold_op);
    else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && !(idx == 4 && rx_q.size() == 4); k++) begin
      if (idx < 4) begin
        in_valid = 1'b1;
        in_a = ba[idx]; in_b = bb[idx]; in_op = bo[idx];
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick(acc);
    n_total++; if (idx != 4 || rx_q.size() != 4) $display("FAIL bp_drain: got accepts=%0d results=%0d want 4/4", idx, rx_q.size()); else n_pass++;
    for (int i = 0; i < 4 && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (r.y !== e.y || r.op !== bo[i] || r.z !== e.z)
        $display("FAIL bp_order[%0d]: got y=%h op=%0d z=%0b want y=%h op=%0d z=%0b", i, r.y, r.op, r.z, e.y, bo[i], e.z);
      else n_pass++;
    end
    clear_queues();
  endtask

  task automatic test_zero_parity();
    bit    acc;
    beat_t r;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 8'hAA; in_b = 8'h55; in_op = 3'd0;
    tick(acc);
    in_a = 8'h07; in_b = 8'h00; in_op = 3'd6;
    tick(acc);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && rx_q.size() < 2; k++) tick(acc);
    n_total++; if (rx_q.size() != 2) $display("FAIL zp_count: got %0d want 2", rx_q.size()); else n_pass++;
    if (rx_q.size() == 2) begin
      r = rx_q.pop_front();
      n_total++; if (r.y !== 8'h00 || r.z !== 1'b1) $display("FAIL zero_and: got y=%h z=%0b want y=00 z=1", r.y, r.z); else n_pass++;
      r = rx_q.pop_front();
      n_total++; if (r.y !== 8'h07 || r.z !== 1'b0) $display("FAIL pass_a: got y=%h z=%0b want y=07 z=0", r.y, r.z); else n_pass++;
`ifdef MUX_GATE_PIPE_PARITY_EN
      n_total++; if (r.p !== 1'b1) $display("FAIL parity: got %0b want 1", r.p); else n_pass++;
`endif
    end
    clear_queues();
  endtask

  task automatic test_wrap();
    bit    acc;
    int    sent, consumed;
    beat_t e, r;
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    clear_queues();
    cnt_model = '0;
    n_total++; if (done_cnt !== 4'd0) $display("FAIL wrap_start: got %0d want 0", done_cnt); else n_pass++;
    out_ready = 1'b1;
    sent = 0;
    consumed = 0;
    for (int k = 0; k < 40 && consumed < 17; k++) begin
      if (sent < 17) begin
        in_valid = 1'b1;
        in_a  = 8'($urandom);
        in_b  = 8'($urandom);
        in_op = 3'($urandom_range(0, 7));
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
      if (acc) sent++;
      consumed = rx_q.size();
      if (consumed == 16) begin
        n_total++; if (done_cnt !== 4'd0) $display("FAIL wrap_at16: got %0d want 0", done_cnt); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_total++; if (consumed != 17) $display("FAIL wrap_count: got %0d want 17", consumed); else n_pass++;
    n_total++; if (done_cnt !== 4'd1) $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (done_cnt !== cnt_model) $display("FAIL wrap_model: got %0d want %0d", done_cnt, cnt_model); else n_pass++;
    for (int i = 0; i < 17 && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (r.y !== e.y || r.op !== e.op || r.z !== e.z)
        $display("FAIL wrap_data[%0d]: got y=%h op=%0d z=%0b want y=%h op=%0d z=%0b", i, r.y, r.op, r.z, e.y, e.op, e.z);
      else n_pass++;
    end
    clear_queues();
  endtask

  task automatic test_async_reset();
    bit    acc;
    beat_t e, r;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 8'h12; in_b = 8'h34; in_op = 3'd4;
    tick(acc);
    in_a = 8'h56; in_b = 8'h78; in_op = 3'd1;
    tick(acc);
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || done_cnt !== 4'd1) $display("FAIL ar_pre: got v=%0b cnt=%0d want v=1 cnt=1", out_valid, done_cnt); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (done_cnt !== 4'd0) $display("FAIL ar_done_cnt: got %0d want 0", done_cnt); else n_pass++;
    n_total++; if (out_y !== 8'h00 || out_zero !== 1'b1) $display("FAIL ar_out_y: got %h/%0b want 00/1", out_y, out_zero); else n_pass++;
    clear_queues();
    cnt_model = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL ar_release: got rdy=%0b v=%0b want rdy=1 v=0", in_ready, out_valid); else n_pass++;
    @(posedge clk);
    cyc++;
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 8'h9A; in_b = 8'h3C; in_op = 3'd3;
    tick(acc);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick(acc);
    n_total++; if (rx_q.size() != 1 || exp_q.size() != 1) $display("FAIL ar_count: got %0d want 1", rx_q.size()); else n_pass++;
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      n_total++; if (r.y !== 8'h41 || r.op !== 3'd3) $display("FAIL ar_result: got y=%h op=%0d want y=41 op=3", r.y, r.op); else n_pass++;
      n_total++; if (r.cyc - e.cyc != 2) $display("FAIL ar_latency: got %0d want 2", r.cyc - e.cyc); else n_pass++;
    end
    n_total++; if (done_cnt !== 4'd1) $display("FAIL ar_done_after: got %0d want 1", done_cnt); else n_pass++;
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_truth_w1();
    test_backpressure();
    test_zero_parity();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
